// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage: memory-stage control bits
// and the payload-width helper used to size each slot register.
package pipe_pkg;

    typedef struct packed {
        logic mem_bypass;
        logic mem_we;
        logic mux;
    } ctrl_t;

    localparam int CTRL_W     = $bits(ctrl_t);
    localparam int DEF_DATA_W = 16;
    localparam int DEF_WA_W   = 5;

    // Slot payload at the core's native widths; wider builds define their
    // own payload struct locally from the module parameters.
    typedef struct packed {
        ctrl_t                 ctrl;
        logic [DEF_DATA_W-1:0] rd2;
        logic [DEF_WA_W-1:0]   wa;
    } slot_t;

    function automatic int payload_w(input int ctrl_w, input int data_w, input int wa_w);
        return ctrl_w + data_w + wa_w;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One entry of the elastic stage: a valid bit plus a payload register.
// Clear beats load; the payload is kept when the entry is cleared.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int W = payload_w(CTRL_W, DEF_DATA_W, DEF_WA_W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process ordering.
    // NOTE: the payload is reset as well as the valid bit, so out_rd2 and
    // out_wa read zero after reset instead of X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic stage register with a two-entry skid buffer, synchronous flush
// and squashing of control bits whenever the stage holds no live beat.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int WA_W   = 5,
    parameter int CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_rd2,
    input  logic [WA_W-1:0]   in_wa,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_rd2,
    output logic [WA_W-1:0]   out_wa,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] rd2;
        logic [WA_W-1:0]   wa;
    } payload_t;

    localparam int PAYLOAD_W = payload_w(CTRL_W, DATA_W, WA_W);

    payload_t in_beat, main_d, main_q, skid_q;
    logic     main_valid, skid_valid;
    logic     main_load, main_clear, skid_load, skid_clear;
    logic     accept, pop;

    assign in_beat = '{ctrl: in_ctrl, rd2: in_rd2, wa: in_wa};

    // in_ready comes straight from the skid flop, so upstream never sees a
    // combinational path from out_ready.
    assign in_ready = ~skid_valid;
    assign accept   = in_valid & ~skid_valid;
    assign pop      = main_valid & out_ready;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_d     = in_beat;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (pop && skid_valid) begin
            main_load  = 1'b1;
            main_d     = skid_q;
            skid_clear = 1'b1;
        end else if (accept && (!main_valid || pop)) begin
            main_load = 1'b1;
        end else if (accept) begin
            skid_load = 1'b1;
        end else if (pop) begin
            main_clear = 1'b1;
        end
    end

    pipe_slot #(.W(PAYLOAD_W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    pipe_slot #(.W(PAYLOAD_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_beat),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_q.ctrl : '0;
    assign out_rd2   = main_q.rd2;
    assign out_wa    = main_q.wa;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a queue model for the default build and an
// in-order scoreboard for a 32-bit data / 6-bit address build.
module tb_pipe_stage_elastic;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    // default build
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [2:0]  in_ctrl = '0, out_ctrl;
    logic [15:0] in_rd2 = '0, out_rd2;
    logic [4:0]  in_wa = '0, out_wa;
    logic [1:0]  occupancy;

    // wide build
    logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1;
    logic [2:0]  s_in_ctrl = '0, s_out_ctrl;
    logic [31:0] s_in_rd2 = '0, s_out_rd2;
    logic [5:0]  s_in_wa = '0, s_out_wa;
    logic [1:0]  s_occupancy;

    int errors = 0;
    int checks = 0;

    pipe_stage_elastic dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_rd2(in_rd2), .in_wa(in_wa),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_rd2(out_rd2), .out_wa(out_wa),
        .occupancy(occupancy)
    );

    pipe_stage_elastic #(.DATA_W(32), .WA_W(6)) dut_wide (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_ctrl(s_in_ctrl), .in_rd2(s_in_rd2), .in_wa(s_in_wa),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_ctrl(s_out_ctrl), .out_rd2(s_out_rd2), .out_wa(s_out_wa),
        .occupancy(s_occupancy)
    );

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [15:0] rd2;
        logic [4:0]  wa;
    } beat_t;

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] rd2;
        logic [5:0]  wa;
    } wide_beat_t;

    // Model: the stage is a FIFO of at most two beats; outputs show the
    // oldest beat, or the last beat shown once the FIFO drains.
    beat_t mq[$];
    beat_t last_beat = '0;

    function automatic logic [27:0] obs();
        return {out_valid, out_ctrl, out_rd2, out_wa, occupancy, in_ready};
    endfunction

    function automatic logic [27:0] exp_vec();
        logic [2:0] c;
        c = (mq.size() > 0) ? mq[0].ctrl : 3'b000;
        return {mq.size() > 0, c, last_beat.rd2, last_beat.wa, 2'(mq.size()), mq.size() < 2};
    endfunction

    task automatic model_reset();
        mq.delete();
        last_beat = '0;
    endtask

    // Drive one cycle on the default build and advance the model across
    // the edge; returns #1 after the edge with outputs settled.
    task automatic step(input logic v, input logic [2:0] c, input logic [15:0] r,
                        input logic [4:0] w, input logic ordy, input logic fl);
        logic  m_ready;
        beat_t b;
        in_valid  = v;
        in_ctrl   = c;
        in_rd2    = r;
        in_wa     = w;
        out_ready = ordy;
        flush     = fl;
        m_ready   = (mq.size() < 2);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && ordy) b = mq.pop_front();
            if (v && m_ready) mq.push_back('{ctrl: c, rd2: r, wa: w});
        end
        if (mq.size() > 0) last_beat = mq[0];
        #1;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 28'h0000001) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs(), 28'h0000001);
        end
        checks++;
        if (obs() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model: got %h want %h", obs(), exp_vec());
        end
        rst = 1'b1;
    endtask

    task automatic test_stream();
        logic [4:0]  w;
        logic [15:0] r;
        for (int k = 1; k <= 4; k++) begin
            w = 5'(k);
            r = 16'h1111 * 16'(k);
            step(1'b1, 3'(k), r, w, 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_wa !== w || out_rd2 !== r ||
                occupancy !== 2'd1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_beat%0d: got v=%b wa=%h rd2=%h occ=%0d rdy=%b want v=1 wa=%h rd2=%h occ=1 rdy=1",
                         k, out_valid, out_wa, out_rd2, occupancy, in_ready, w, r);
            end
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL stream_model%0d: got %h want %h", k, obs(), exp_vec());
            end
        end
        step(1'b0, 3'b000, 16'h0, 5'h0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
        end
    endtask

    task automatic test_back_pressure();
        logic [4:0] exp_wa [2];
        exp_wa[0] = 5'd6;
        exp_wa[1] = 5'd7;
        step(1'b1, 3'b001, 16'h5555, 5'd5, 1'b0, 1'b0);
        step(1'b1, 3'b001, 16'h6666, 5'd6, 1'b0, 1'b0);
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_wa !== 5'd5) begin
            errors++;
            $display("FAIL bp_full: got occ=%0d rdy=%b wa=%0d want occ=2 rdy=0 wa=5", occupancy, in_ready, out_wa);
        end
        step(1'b1, 3'b001, 16'h7777, 5'd7, 1'b0, 1'b0);
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_wa !== 5'd5 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: got occ=%0d rdy=%b wa=%0d want occ=2 rdy=0 wa=5", occupancy, in_ready, out_wa);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 3'b001, 16'h7777, 5'd7, 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_wa !== exp_wa[i]) begin
                errors++;
                $display("FAIL bp_order%0d: got v=%b wa=%0d want v=1 wa=%0d", i, out_valid, out_wa, exp_wa[i]);
            end
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL bp_model%0d: got %h want %h", i, obs(), exp_vec());
            end
        end
        step(1'b0, 3'b000, 16'h0, 5'h0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_wa !== 5'd7) begin
            errors++;
            $display("FAIL bp_drain: got v=%b occ=%0d wa=%0d want v=0 occ=0 wa=7", out_valid, occupancy, out_wa);
        end
    endtask

    task automatic test_flush();
        step(1'b1, 3'b111, 16'hAAAA, 5'h0A, 1'b0, 1'b0);
        step(1'b1, 3'b111, 16'hBBBB, 5'h0B, 1'b0, 1'b0);
        checks++;
        if (occupancy !== 2'd2) begin
            errors++;
            $display("FAIL flush_fill: got occ=%0d want occ=2", occupancy);
        end
        step(1'b1, 3'b010, 16'h9999, 5'd9, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 3'b000 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: got v=%b ctrl=%b occ=%0d rdy=%b want v=0 ctrl=000 occ=0 rdy=1",
                     out_valid, out_ctrl, occupancy, in_ready);
        end
        // flush together with an accept and a pop from a half-full stage
        step(1'b1, 3'b100, 16'hCCCC, 5'h0C, 1'b0, 1'b0);
        step(1'b1, 3'b010, 16'h9999, 5'd9, 1'b1, 1'b1);
        checks++;
        if (obs() !== exp_vec()) begin
            errors++;
            $display("FAIL flush_pop_model: got %h want %h", obs(), exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 3'b000, 16'h0, 5'h0, 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b0 || out_wa === 5'd9) begin
                errors++;
                $display("FAIL flush_discard%0d: got v=%b wa=%0d want v=0 wa!=9", i, out_valid, out_wa);
            end
        end
    endtask

    task automatic test_squash();
        step(1'b1, 3'b010, 16'h1234, 5'h0D, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 3'b010) begin
            errors++;
            $display("FAIL squash_live: got v=%b ctrl=%b want v=1 ctrl=010", out_valid, out_ctrl);
        end
        step(1'b0, 3'b000, 16'h0, 5'h0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 3'b000 || out_wa !== 5'h0D || out_rd2 !== 16'h1234) begin
            errors++;
            $display("FAIL squash_bubble: got v=%b ctrl=%b wa=%h rd2=%h want v=0 ctrl=000 wa=0d rd2=1234",
                     out_valid, out_ctrl, out_wa, out_rd2);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 3'b101, 16'h1111, 5'h11, 1'b0, 1'b0);
        step(1'b1, 3'b101, 16'h2222, 5'h12, 1'b0, 1'b0);
        checks++;
        if (occupancy !== 2'd2) begin
            errors++;
            $display("FAIL areset_fill: got occ=%0d want occ=2", occupancy);
        end
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs() !== 28'h0000001) begin
            errors++;
            $display("FAIL areset_immediate: got %h want %h", obs(), 28'h0000001);
        end
        #1;
        rst = 1'b1;
        step(1'b1, 3'b011, 16'hFFFF, 5'h1F, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_wa !== 5'h1F || out_rd2 !== 16'hFFFF || out_ctrl !== 3'b011) begin
            errors++;
            $display("FAIL areset_first_beat: got v=%b wa=%h rd2=%h ctrl=%b want v=1 wa=1f rd2=ffff ctrl=011",
                     out_valid, out_wa, out_rd2, out_ctrl);
        end
        step(1'b0, 3'b000, 16'h0, 5'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom), 5'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                bad++;
                if (bad <= 5) $display("FAIL random_model cycle %0d: got %h want %h", i, obs(), exp_vec());
            end
        end
        step(1'b0, 3'b000, 16'h0, 5'h0, 1'b1, 1'b0);
        step(1'b0, 3'b000, 16'h0, 5'h0, 1'b1, 1'b0);
    endtask

    // Wide build: everything accepted must come out once, in order, intact.
    task automatic test_param_sweep();
        wide_beat_t sent[$];
        wide_beat_t exp_b;
        int accepted, delivered, marked, bad;
        logic mark;
        accepted = 0;
        delivered = 0;
        marked = 0;
        bad = 0;
        for (int k = 0; k < 460; k++) begin
            mark = (k % 3 == 0);
            if (k < 400) begin
                s_in_valid  = 1'($urandom_range(0, 1));
                s_out_ready = 1'($urandom_range(0, 1));
            end else begin
                s_in_valid  = 1'b0;
                s_out_ready = 1'b1;
            end
            s_in_ctrl = 3'($urandom);
            s_in_rd2  = mark ? 32'hDEADBEEF : $urandom;
            s_in_wa   = mark ? 6'h3F : 6'($urandom);
            checks++;
            if (s_occupancy !== 2'(sent.size()) || s_in_ready !== (sent.size() < 2) ||
                s_out_valid !== (sent.size() > 0) ||
                (s_out_valid === 1'b0 && s_out_ctrl !== 3'b000)) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL sweep_state cycle %0d: got occ=%0d rdy=%b v=%b ctrl=%b want occ=%0d",
                             k, s_occupancy, s_in_ready, s_out_valid, s_out_ctrl, sent.size());
            end
            if (s_out_valid && s_out_ready && sent.size() > 0) begin
                exp_b = sent.pop_front();
                checks++;
                if ({s_out_ctrl, s_out_rd2, s_out_wa} !== exp_b) begin
                    errors++;
                    bad++;
                    if (bad <= 5)
                        $display("FAIL sweep_order: got %h want %h", {s_out_ctrl, s_out_rd2, s_out_wa}, exp_b);
                end else begin
                    delivered++;
                    if (exp_b.rd2 == 32'hDEADBEEF && exp_b.wa == 6'h3F) marked++;
                end
            end
            if (s_in_valid && s_in_ready) begin
                sent.push_back('{ctrl: s_in_ctrl, rd2: s_in_rd2, wa: s_in_wa});
                accepted++;
            end
            @(posedge clk);
            #1;
        end
        s_in_valid = 1'b0;
        checks++;
        if (sent.size() != 0 || delivered != accepted || accepted == 0) begin
            errors++;
            $display("FAIL sweep_loss: got delivered=%0d left=%0d want delivered=%0d left=0",
                     delivered, sent.size(), accepted);
        end
        checks++;
        if (marked == 0) begin
            errors++;
            $display("FAIL sweep_marked: got %0d deadbeef/3f beats delivered want >0", marked);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_squash();
        test_async_reset();
        test_random();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline stage register, the successor to the fixed EX/MEM stage register. It carries the memory-stage control bits, store data and write-back address. Unlike a plain clocked register it supports a valid/ready handshake with a two-entry skid buffer, a synchronous flush, and squashing of control bits on bubbles. It sits between any two stages of the 16-bit core, so back-pressure from a slow stage never drops or duplicates an instruction.

## Interface
Parameters:
- DATA_W, 16, store-data (rd2) width
- WA_W, 5, write-back register address width
- CTRL_W, $bits(pipe_pkg::ctrl_t) = 3, control field width (mem_bypass, mem_we, mux)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous kill of all held entries
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage can accept a beat; registered, equals !skid_valid
- in_ctrl  input  CTRL_W  control bits {mem_bypass, mem_we, mux}
- in_rd2  input  DATA_W  store data
- in_wa  input  WA_W  write-back address
- out_valid  output  1  main entry holds a live beat
- out_ready  input  1  downstream accepts beat
- out_ctrl  output  CTRL_W  main entry control; forced to 0 when !out_valid
- out_rd2  output  DATA_W  main entry store data
- out_wa  output  WA_W  main entry write-back address
- occupancy  output  2  live entries held (0..2)

## Operation
- Two slots: main (drives outputs) and skid (overflow). Each slot holds a valid bit and a payload.
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- Main empty, or popping with skid empty: an accepted beat loads main directly.
- Main full, not popping, accept: the beat loads skid; in_ready drops next cycle.
- Pop with skid full: skid moves to main and skid clears. An accept is impossible in that cycle because in_ready=0.
- Pop, no accept, skid empty: main valid clears. Payload data is held; out_ctrl reads 0.
- flush=1: both valid bits clear next edge. Any beat accepted that cycle is discarded. Flush has priority over accept and pop. occupancy=0 next cycle.
- Squash: out_ctrl = out_valid ? main.ctrl : '0. An invalid stage never asserts mem_we.
- Beats leave in arrival order. No beat is ever duplicated or lost except under flush.

## Timing
- Reset (rst=0, async): both valid bits=0, payloads=0, out_ctrl=0, out_rd2=0, out_wa=0, out_valid=0, occupancy=0, in_ready=1.
- Latency: 1 cycle from accept to out_valid when main is empty or popping.
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready has no combinational path from out_ready or in_valid; it is a register output.
- out_* have no combinational path from in_*.
- Release of rst mid-operation: the stage starts empty, and the first accept is allowed on the first edge after release.
- Simultaneous flush and pop: downstream has consumed the beat, and the stage still empties.

## Structure
- Package pipe_pkg holds:
  - typedef struct packed {logic mem_bypass; logic mem_we; logic mux;} ctrl_t
  - typedef of the slot payload struct, parametrised via module-level widths
  - CTRL_W constant
- One sub-module is natural: pipe_slot, a single valid+payload register with load, clear and async reset. It is instantiated twice (main, skid).
- The top level holds the steering and occupancy logic only.

## Test plan
- Reset then stream: out_ready=1; feed wa=1..4 with rd2=0x1111·wa, one per cycle. Required: each appears on out_* exactly 1 cycle later, in_ready stays 1, occupancy stays 1.
- Back-pressure: out_ready=0 with beats wa=5,6,7 offered. Required: wa=5 in main, wa=6 in skid, in_ready=0 from the cycle after wa=6, wa=7 held upstream. Then out_ready=1: outputs 5,6,7 in order with no gaps.
- Flush while full: occupancy=2, then flush=1 with in_valid=1 (wa=9). Required: next cycle out_valid=0, out_ctrl=0, occupancy=0, and wa=9 never emitted.
- Squash: a single beat with ctrl=3'b010 (mem_we) is popped with no refill. Required: next cycle out_valid=0 and out_ctrl=3'b000 while out_wa keeps its last value.
- Async reset mid-stream: assert rst=0 between edges with occupancy=2. Required: outputs go to 0 immediately and in_ready=1. After release, beat wa=0x1F with rd2=0xFFFF passes with 1-cycle latency.
- Parameter sweep: DATA_W=32, WA_W=6. Required: rd2=0xDEADBEEF and wa=0x3F pass unmodified under random in_valid/out_ready; the scoreboard shows in-order delivery with zero loss.
